// File: rtl/seq_alu.sv
// seq_alu: multi-cycle unsigned ALU with add, sub, shift-add mul and scaled restoring div
module seq_alu #(
   parameter int WIDTH      = 16,
   parameter int FRAC_SCALE = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   num1,
   input  logic [WIDTH-1:0]   num2,
   input  logic [1:0]         op_code,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               is_division,
   output logic               div_by_zero,
   output logic               borrow
);
   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(W2) + 1;
   typedef enum logic [1:0] {IDLE, SCALE, ITER, FIN} state_t;
   state_t            state, state_nx;
   logic [WIDTH-1:0]  a, b, rem, r_nx;
   logic [1:0]        opr;
   logic [W2-1:0]     acc, mc;
   logic [CW-1:0]     cnt;
   logic [WIDTH:0]    r_sh;
   logic              ge;
   assign busy = (state != IDLE);
   // next-state: zero divisor skips straight to FIN, mul skips SCALE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = !start ? IDLE : op_code == 2'b10 ? ITER :
                             (op_code == 2'b11 && num2 != '0) ? SCALE : FIN;
         SCALE:   state_nx = ITER;
         ITER:    state_nx = cnt == '0 ? FIN : ITER;
         default: state_nx = IDLE;
      endcase
   end
   // one restoring-division step: remainder shifted with next dividend bit, trial subtract
   always_comb begin
      r_sh = {rem, acc[W2-1]};
      ge   = r_sh >= {1'b0, b};
      r_nx = ge ? r_sh[WIDTH-1:0] - b : r_sh[WIDTH-1:0];
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   // datapath: operand latch, scaling, and per-cycle mul/div iteration
   always_ff @(posedge clk) begin
      if (rst) begin
         a   <= '0;
         b   <= '0;
         opr <= '0;
         acc <= '0;
         mc  <= '0;
         rem <= '0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a   <= num1;
               b   <= num2;
               opr <= op_code;
               acc <= '0;
               mc  <= {{WIDTH{1'b0}}, num1};
               cnt <= CW'(WIDTH - 1);
            end
            SCALE: begin
               acc <= {{WIDTH{1'b0}}, a} * W2'(FRAC_SCALE);
               rem <= '0;
               cnt <= CW'(W2 - 1);
            end
            ITER: begin
               if (opr == 2'b10) begin
                  acc <= acc + (b[0] ? mc : '0);
                  mc  <= mc << 1;
                  b   <= b >> 1;
               end else begin
                  rem <= r_nx;
                  acc <= {acc[W2-2:0], ge};
               end
               cnt <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end
   // completion: publish result and flags, pulse done
   always_ff @(posedge clk) begin
      if (rst) begin
         done        <= 1'b0;
         result      <= '0;
         is_division <= 1'b0;
         div_by_zero <= 1'b0;
         borrow      <= 1'b0;
      end else begin
         done <= (state == FIN);
         if (state == FIN) begin
            result      <= opr == 2'b00 ? {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b} :
                           opr == 2'b01 ? {{WIDTH{1'b0}}, a - b} :
                           opr == 2'b10 ? acc : (b == '0 ? '1 : acc);
            is_division <= opr == 2'b11;
            div_by_zero <= opr == 2'b11 && b == '0;
            borrow      <= opr == 2'b01 && a < b;
         end
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector bench for seq_alu across three parameterisations
module tb_seq_alu;
   logic        clk = 0, rst = 1, start = 1;
   logic [1:0]  op = 0;
   logic [15:0] n1 = 1, n2 = 1, r8;
   logic [31:0] res [3];
   logic        dn [3], bz [3], idv [3], dz [3], br [3];
   int          tests = 0, fails = 0;
   typedef struct {
      logic [1:0]  o;
      logic [15:0] x, y;
      logic [31:0] r;
      int          l;
      logic        fi, fz, fb;
   } vec_t;
   vec_t v [14];
   always #5 clk = ~clk;
   seq_alu #(.WIDTH(16), .FRAC_SCALE(10)) u0 (.clk(clk), .rst(rst), .num1(n1), .num2(n2),
      .op_code(op), .start(start), .busy(bz[0]), .done(dn[0]), .result(res[0]),
      .is_division(idv[0]), .div_by_zero(dz[0]), .borrow(br[0]));
   seq_alu #(.WIDTH(16), .FRAC_SCALE(100)) u1 (.clk(clk), .rst(rst), .num1(n1), .num2(n2),
      .op_code(op), .start(start), .busy(bz[1]), .done(dn[1]), .result(res[1]),
      .is_division(idv[1]), .div_by_zero(dz[1]), .borrow(br[1]));
   seq_alu #(.WIDTH(8), .FRAC_SCALE(10)) u8 (.clk(clk), .rst(rst), .num1(n1[7:0]), .num2(n2[7:0]),
      .op_code(op), .start(start), .busy(bz[2]), .done(dn[2]), .result(r8),
      .is_division(idv[2]), .div_by_zero(dz[2]), .borrow(br[2]));
   assign res[2] = {16'h0, r8};
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic do_op(input int s, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        output logic [31:0] r, output int lat, output logic fi, output logic fz,
                        output logic fb);
      int w = 0;
      while (bz[s] && w < 100) begin @(negedge clk); w++; end
      @(negedge clk);
      op = o; n1 = x; n2 = y; start = 1;
      @(posedge clk); #1;
      chk("busy_at_accept", 32'(bz[s]), 1);
      @(negedge clk);
      start = 0; n1 = ~x; n2 = ~y; op = ~o;
      lat = 0;
      while (lat < 200) begin
         @(posedge clk); lat++; #1;
         if (dn[s]) break;
      end
      chk("busy_at_done", 32'(bz[s]), 0);
      r = res[s]; fi = idv[s]; fz = dz[s]; fb = br[s];
   endtask
   initial begin
      logic [31:0] r;
      logic        fi, fz, fb;
      int          lat, dl, dones;
      v[0]  = '{2'b00, 16'd15,    16'd15,  32'd30,        1,  1'b0, 1'b0, 1'b0};
      v[1]  = '{2'b01, 16'd20,    16'd8,   32'd12,        1,  1'b0, 1'b0, 1'b0};
      v[2]  = '{2'b01, 16'd8,     16'd20,  32'h0000FFF4,  1,  1'b0, 1'b0, 1'b1};
      v[3]  = '{2'b00, 16'hFFFF,  16'd1,   32'h00010000,  1,  1'b0, 1'b0, 1'b0};
      v[4]  = '{2'b10, 16'd12,    16'd120, 32'd1440,      17, 1'b0, 1'b0, 1'b0};
      v[5]  = '{2'b10, 16'hFFFF,  16'hFFFF,32'hFFFE0001,  17, 1'b0, 1'b0, 1'b0};
      v[6]  = '{2'b10, 16'd0,     16'd5,   32'd0,         17, 1'b0, 1'b0, 1'b0};
      v[7]  = '{2'b11, 16'd15,    16'd2,   32'd75,        34, 1'b1, 1'b0, 1'b0};
      v[8]  = '{2'b11, 16'd135,   16'd7,   32'd192,       34, 1'b1, 1'b0, 1'b0};
      v[9]  = '{2'b11, 16'd1,     16'd3,   32'd3,         34, 1'b1, 1'b0, 1'b0};
      v[10] = '{2'b11, 16'd9,     16'd0,   32'hFFFFFFFF,  1,  1'b1, 1'b1, 1'b0};
      v[11] = '{2'b01, 16'd5,     16'd5,   32'd0,         1,  1'b0, 1'b0, 1'b0};
      v[12] = '{2'b11, 16'hFFFF,  16'd1,   32'h0009FFF6,  34, 1'b1, 1'b0, 1'b0};
      v[13] = '{2'b10, 16'd3,     16'd1,   32'd3,         17, 1'b0, 1'b0, 1'b0};
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_busy", 32'(bz[0]), 0);
         chk("rst_done", 32'(dn[0]), 0);
         chk("rst_result", res[0], 0);
      end
      chk("rst_flags", {29'b0, idv[0], dz[0], br[0]}, 0);
      @(negedge clk);
      rst = 0; start = 0;
      for (int i = 0; i < 14; i++) begin
         do_op(0, v[i].o, v[i].x, v[i].y, r, lat, fi, fz, fb);
         chk($sformatf("v%0d_result", i), r, v[i].r);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].l));
         chk($sformatf("v%0d_flags", i), {29'b0, fi, fz, fb}, {29'b0, v[i].fi, v[i].fz, v[i].fb});
      end
      @(negedge clk);
      op = 2'b11; n1 = 16'd135; n2 = 16'd7; start = 1;
      @(posedge clk);
      @(negedge clk);
      start = 0; dl = 0; dones = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 5) begin start = 1; op = 2'b00; n1 = 16'd1; n2 = 16'd1; end
         else start = 0;
         if (dn[0]) begin
            dones++;
            if (dl == 0) begin dl = c; r = res[0]; end
         end
      end
      chk("poke_result", r, 32'd192);
      chk("poke_latency", 32'(dl), 34);
      chk("poke_dones", 32'(dones), 1);
      @(negedge clk);
      op = 2'b11; n1 = 16'd135; n2 = 16'd7; start = 1;
      @(posedge clk);
      @(negedge clk);
      start = 0;
      for (int c = 1; c <= 10; c++) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("midrst_busy", 32'(bz[0]), 0);
      chk("midrst_result", res[0], 0);
      chk("midrst_flags", {29'b0, idv[0], dz[0], br[0]}, 0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin @(negedge clk); if (dn[0]) dones++; end
      chk("midrst_nodone", 32'(dones), 0);
      do_op(0, 2'b00, 16'd3, 16'd4, r, lat, fi, fz, fb);
      chk("after_rst_add", r, 32'd7);
      chk("after_rst_lat", 32'(lat), 1);
      do_op(1, 2'b11, 16'd135, 16'd7, r, lat, fi, fz, fb);
      chk("scale100_result", r, 32'd1928);
      chk("scale100_lat", 32'(lat), 34);
      do_op(2, 2'b10, 16'd200, 16'd200, r, lat, fi, fz, fb);
      chk("w8_mul_result", r, 32'd40000);
      chk("w8_mul_lat", 32'(lat), 9);
      @(posedge clk); #1;
      chk("w8_done_drop", 32'(dn[2]), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle unsigned ALU: add, subtract, shift-add multiply and fixed-point-scaled restoring divide on two WIDTH-bit operands.
- Result is 2*WIDTH bits. Division returns floor(num1*FRAC_SCALE/num2), i.e. a decimal fixed-point quotient.
- Successor to the single-width ALU. Adds width/scale parameters, a busy output, divide-by-zero and borrow flags, and fixed, documented latencies.
- Sits behind a control FSM that issues one operation at a time using a start/done handshake.

Parameters:
- WIDTH, 16, operand width in bits. Legal values are 4 to 32.
- FRAC_SCALE, 10, division scale factor applied to num1 before dividing. Must satisfy 1 <= FRAC_SCALE < 2**WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- num1  in  WIDTH  operand A (dividend, minuend).
- num2  in  WIDTH  operand B (divisor, subtrahend).
- op_code  in  2  00 add, 01 sub, 10 mul, 11 scaled div.
- start  in  1  request. Sampled only in IDLE.
- busy  out  1  high from the accept edge until the done edge.
- done  out  1  one-cycle completion pulse.
- result  out  2*WIDTH  result of the last completed operation.
- is_division  out  1  last completed operation was op 11.
- div_by_zero  out  1  last completed operation was a divide with num2 == 0.
- borrow  out  1  last completed operation was a subtract with num1 < num2.

Behaviour:
- Reset (rst high at an edge) forces state IDLE. busy, done, result, is_division, div_by_zero and borrow are all 0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE: wait for start.
  - SCALE: divide only; computes the scaled dividend.
  - ITER: shift iterations with a counter.
  - FIN: writes the outputs.
- Accept:
  - At edge k, in IDLE with start high: latch num1, num2 and op_code, and set busy.
  - start in any other state is ignored; it is neither queued nor allowed to corrupt the running operation.
  - Operands may change after edge k without effect.
- Latency L is counted from accept edge k to the edge at which done goes high (k+L):
  - add/sub: L=1 (IDLE->FIN).
  - mul: L=WIDTH+1 (ITER runs WIDTH edges, then FIN).
  - div: L=2*WIDTH+2 (SCALE, then ITER runs 2*WIDTH edges, then FIN).
  - div with num2==0: L=1 (IDLE->FIN directly).
- At edge k+L: result and the flags update, done=1 and busy=0. State returns to IDLE at that edge. done drops at edge k+L+1.
- Back-to-back operation: a new start may be accepted at edge k+L+1 (when done is low and IDLE has been re-entered).
- result, is_division, div_by_zero and borrow hold their values until the next completion or reset.
- add: result = zero-extended num1+num2; the carry lands in bit WIDTH.
- sub: result = zero-extended (num1-num2) mod 2**WIDTH, with borrow = (num1<num2). Upper WIDTH bits are 0.
- mul: unsigned shift-add, one multiplier bit per ITER cycle. The full 2*WIDTH-bit product never overflows.
- div:
  - The scaled dividend D = num1*FRAC_SCALE is computed at 2*WIDTH bits and always fits.
  - A restoring divider processes one bit per ITER cycle and produces floor(D/num2). The remainder is discarded.
- div by zero: result = all ones, div_by_zero=1, is_division=1.
- Flags not relevant to the completed operation are cleared at completion. is_division = (op_code==11).

Test Plan:
- Reset: hold rst 3 cycles while start=1 -> all outputs 0, busy never asserts. Release, then add 15+15 -> result=30, done 1 cycle after accept, borrow=0.
- Subtract:
  - 20-8 -> result=12, borrow=0.
  - 8-20 -> result=0x0000FFF4, borrow=1.
  - Add 65535+1 -> result=0x00010000.
- Multiply:
  - 12*120 -> result=1440, done exactly 17 cycles after accept.
  - 65535*65535 -> 0xFFFE0001.
  - 0*5 -> 0.
- Divide:
  - 15/2 -> 75; 135/7 -> 192; each with is_division=1 and done 34 cycles after accept.
  - 1/3 -> 3.
  - With FRAC_SCALE=100, 135/7 -> 1928.
- Divide by zero: 9/0 -> result=0xFFFFFFFF, div_by_zero=1, done 1 cycle after accept.
- Robustness:
  - Pulse start with op 00 during a running divide -> the divide result is unaffected and no extra done pulse appears.
  - Assert rst at cycle 10 of a divide -> no done pulse, outputs 0, next add completes normally.
  - WIDTH=8 instance: 200*200 -> 40000.
